// File: rtl/captura_jogada.sv
// Push-button capture block: synchronizes four raw buttons, debounces press and release,
// latches the accepted pattern and reports wait timeouts for the game controller.
module captura_jogada #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita_i,
  input  logic       zera_i,
  input  logic [3:0] chaves_i,
  output logic [3:0] jogada_o,
  output logic       jogada_feita_o,
  output logic       multipla_o,
  output logic       timeout_o,
  output logic [3:0] db_estado_o
);

  localparam int DB_W = $clog2(DEBOUNCE) + 1;
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic [3:0] {
    INATIVO  = 4'h0,
    ESPERA   = 4'h1,
    FILTRA   = 4'h2,
    REGISTRA = 4'h3,
    SOLTA    = 4'h4,
    ESGOTADO = 4'hF
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [3:0]      sync1_q, s_q;
  logic [3:0]      cand_q, cand_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [3:0]      jogada_q, jogada_d;
  logic            multipla_q, multipla_d;

  // NOTE: every output of this block gets a default before the case, so no path infers a latch.
  always_comb begin
    estado_d   = estado_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    jogada_d   = jogada_q;
    multipla_d = multipla_q;

    if (zera_i) begin
      jogada_d   = '0;
      multipla_d = 1'b0;
    end

    case (estado_q)
      INATIVO: begin
        cnt_d = '0;
        if (habilita_i) estado_d = ESPERA;
      end
      ESPERA: begin
        tmo_d = (tmo_q == TO_LAST) ? tmo_q : tmo_q + TO_ONE;
        if (!habilita_i) begin
          estado_d = INATIVO;
        end else if (s_q != 4'd0) begin
          estado_d = FILTRA;
          cand_d   = s_q;
          cnt_d    = DB_ONE;
        end else if (tmo_q == TO_LAST) begin
          estado_d = ESGOTADO;
        end
      end
      FILTRA: begin
        // The wait budget keeps running through bounces back to ESPERA.
        tmo_d = (tmo_q == TO_LAST) ? tmo_q : tmo_q + TO_ONE;
        if (!habilita_i) begin
          estado_d = INATIVO;
        end else if (s_q == 4'd0) begin
          estado_d = ESPERA;
        end else if (s_q == cand_q) begin
          if (cnt_q == DB_LAST) estado_d = REGISTRA;
          else                  cnt_d    = cnt_q + DB_ONE;
        end else begin
          cand_d = s_q;
          cnt_d  = DB_ONE;
        end
      end
      REGISTRA: begin
        // Acceptance load overrides a simultaneous zera.
        estado_d   = SOLTA;
        jogada_d   = cand_q;
        multipla_d = |(cand_q & (cand_q - 4'd1));
        cnt_d      = '0;
      end
      SOLTA: begin
        if (!habilita_i) begin
          estado_d = INATIVO;
        end else if (s_q != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      ESGOTADO: estado_d = INATIVO;
      default:  estado_d = INATIVO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INATIVO;
      sync1_q    <= '0;
      s_q        <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      jogada_q   <= '0;
      multipla_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sync1_q    <= chaves_i;
      s_q        <= sync1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      jogada_q   <= jogada_d;
      multipla_q <= multipla_d;
    end
  end

  always_comb begin
    case (estado_q)
      INATIVO, ESPERA, FILTRA, REGISTRA, SOLTA, ESGOTADO: db_estado_o = estado_q;
      default:                                            db_estado_o = 4'hE;
    endcase
  end

  assign jogada_feita_o = (estado_q == REGISTRA);
  assign timeout_o      = (estado_q == ESGOTADO);
  assign jogada_o       = jogada_q;
  assign multipla_o     = multipla_q;

endmodule

// File: doc/captura_jogada.md
CAPTURA_JOGADA -- requirements
Module: captura_jogada

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable synchronized cycles required to accept a press or a release.
REQ-002 Parameter TIMEOUT, default 20: cycles spent in ESPERA before a timeout is declared.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 habilita  input  1  1 = capture active; 0 = force INATIVO.
REQ-006 zera  input  1  synchronous clear of the jogada register.
REQ-007 chaves  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-008 jogada  output  4  last accepted button pattern, held until the next acceptance or zera.
REQ-009 jogada_feita  output  1  one-cycle pulse on acceptance; consumed by the game controller.
REQ-010 multipla  output  1  held flag, 1 if the accepted pattern has more than one bit set.
REQ-011 timeout  output  1  one-cycle pulse when TIMEOUT expires.
REQ-012 db_estado  output  4  current state code, for debug display.

Function
REQ-013 The block SHALL pass chaves through a 2-flop synchronizer; "s" below denotes the synchronizer output; s SHALL lag chaves by 2 cycles.
REQ-014 The block SHALL implement a Moore FSM with these state codes: INATIVO=0, ESPERA=1, FILTRA=2, REGISTRA=3, SOLTA=4, ESGOTADO=F; any other code SHALL drive db_estado=E and SHALL go to INATIVO next cycle.
REQ-015 INATIVO: go to ESPERA when habilita=1; otherwise stay.
REQ-016 ESPERA: go to FILTRA when s!=0, capturing s into a candidate register and loading stability count 1; when the timeout counter reaches TIMEOUT-1 with s=0, go to ESGOTADO; when both conditions hold in the same cycle, the press SHALL win.
REQ-017 FILTRA: if s equals the candidate, increment the count; when the count reaches DEBOUNCE, go to REGISTRA.
REQ-018 FILTRA: if s!=0 and s differs from the candidate, reload the candidate with s and set the count to 1.
REQ-019 FILTRA: if s=0, return to ESPERA; the timeout counter SHALL NOT be cleared by this bounce.
REQ-020 REGISTRA: jogada_feita=1 for exactly this one cycle; jogada<=candidate; multipla<=(popcount(candidate)>1); next state SOLTA.
REQ-021 SOLTA: count consecutive cycles with s=0, restarting the count on any s!=0; after DEBOUNCE zero cycles, go to ESPERA with the timeout counter cleared.
REQ-022 ESGOTADO: timeout=1 for exactly this one cycle; next state INATIVO.
REQ-023 Timeout counter: cleared on entry to ESPERA from INATIVO or SOLTA; increments only in ESPERA and FILTRA; saturates at TIMEOUT-1.
REQ-024 habilita=0 in any state except REGISTRA or ESGOTADO SHALL force INATIVO on the next edge with no pulse generated; a REGISTRA or ESGOTADO pulse already in progress SHALL complete.
REQ-025 zera=1 SHALL clear jogada and multipla to 0 on the next edge, independent of state; if REGISTRA occurs in the same cycle, the REGISTRA load SHALL win.
REQ-026 Counter widths SHALL be $clog2 of the parameter value plus 1; there SHALL be no wrap-around inside any state.
REQ-027 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from chaves to any output.

Reset
REQ-028 reset=1 SHALL asynchronously force INATIVO, synchronizer=0, candidate=0, all counters=0, jogada=0, multipla=0, jogada_feita=0, timeout=0, db_estado=0.
REQ-029 A reset asserted mid-FILTRA or mid-SOLTA SHALL discard the pending press; after release, the FSM SHALL resume in INATIVO and require habilita.

Verification (DEBOUNCE=4, TIMEOUT=20)
REQ-030 Clean press: habilita=1, chaves=0100 held 10 cycles -> exactly one jogada_feita pulse, jogada=0100, multipla=0, db_estado sequence 1,2,3,4.
REQ-031 Bounce: chaves toggles 0010/0000 every 2 cycles for 8 cycles, then holds 0010 -> no pulse during toggling; exactly one pulse 4 stable cycles after the synchronizer output settles.
REQ-032 Multiple buttons: chaves=1001 held -> pulse with jogada=1001, multipla=1; a subsequent zera -> jogada=0000, multipla=0.
REQ-033 Timeout: habilita=1, chaves=0 -> timeout pulse in the 20th ESPERA cycle, db_estado=F then 0, no jogada_feita.
REQ-034 Release filter: after acceptance, chaves glitches to 0 for 2 cycles and then back to 0100 -> stays in SOLTA with no second pulse; 4 zero cycles -> ESPERA.
REQ-035 Abort: habilita=0 during FILTRA -> INATIVO next cycle with no pulse; reset during SOLTA -> every output at its REQ-028 value.
